// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request arbiter: FSM states, owner ids, access sizes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    // Owner ids double as bit positions in the picker's request/grant vectors.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/arb_pick2.sv
// Two-requester picker: a lone request is always granted; on a tie, ptr names the winner.
module arb_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // One-hot grant; ptr only matters when both requesters are asserting.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like master port between instruction fetch (I) and data (D) requesters.
// One transaction is outstanding at a time. Define ARB_ROUND_ROBIN_EN to resolve ties with a
// round-robin pointer; otherwise D always wins a tie.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_addr_ok,
    output logic                i_data_ok,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [1:0]          d_size,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_addr_ok,
    output logic                d_data_ok,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_wr,
    output logic [1:0]          m_size,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    arb_state_t          state_q;
    logic                owner_q;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [1:0] req_vec;
    logic [1:0] grant;
    logic       pick_ptr;
    logic       resp_fire;

    // Requests are only considered while idle and out of reset, so grant doubles as addr_ok.
    assign req_vec = {d_req, i_req} & {2{(state_q == ST_IDLE) && !reset}};

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr_q;

    // Point away from whichever port was just granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= OWN_D;
        end else if (|grant) begin
            rr_ptr_q <= grant[OWN_D] ? OWN_I : OWN_D;
        end
    end

    assign pick_ptr = rr_ptr_q;
`else
    assign pick_ptr = OWN_D;
`endif

    arb_pick2 u_pick (
        .req   (req_vec),
        .ptr   (pick_ptr),
        .grant (grant)
    );

    // FSM plus request latch; the master port is driven only from these registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_D;
            wr_q    <= 1'b0;
            size_q  <= '0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (grant[OWN_D]) begin
                        state_q <= ST_REQ;
                        owner_q <= OWN_D;
                        wr_q    <= d_wr;
                        size_q  <= d_size;
                        wstrb_q <= d_wstrb;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                    end else if (grant[OWN_I]) begin
                        state_q <= ST_REQ;
                        owner_q <= OWN_I;
                        wr_q    <= 1'b0;
                        size_q  <= SZ_WORD;
                        wstrb_q <= '0;
                        addr_q  <= i_addr;
                        wdata_q <= '0;
                    end
                end
                ST_REQ: begin
                    if (m_addr_ok) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (m_data_ok) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign i_addr_ok = grant[OWN_I];
    assign d_addr_ok = grant[OWN_D];

    assign m_req   = (state_q == ST_REQ) && !reset;
    assign m_wr    = wr_q;
    assign m_size  = size_q;
    assign m_wstrb = wstrb_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;

    // Response is steered to the owner; m_data_ok outside RESP is ignored.
    assign resp_fire = (state_q == ST_RESP) && m_data_ok && !reset;
    assign i_data_ok = resp_fire && (owner_q == OWN_I);
    assign d_data_ok = resp_fire && (owner_q == OWN_D);
    assign i_rdata   = i_data_ok ? m_rdata : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbiter.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok, i_data_ok;
    logic [31:0] i_rdata;
    logic        d_req, d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr, d_wdata;
    logic        d_addr_ok, d_data_ok;
    logic [31:0] d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    mem_req_arbiter #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_addr_ok (i_addr_ok),
        .i_data_ok (i_data_ok),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_size    (d_size),
        .d_wstrb   (d_wstrb),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_addr_ok (d_addr_ok),
        .d_data_ok (d_data_ok),
        .d_rdata   (d_rdata),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_size    (m_size),
        .m_wstrb   (m_wstrb),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata)
    );

    typedef struct packed {
        logic        v;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    // Model: pending request per port, the transaction in flight and its progress.
    txn_t pend_i, pend_d, cur;
    logic cur_d;           // 1 when the in-flight transaction belongs to D
    int   phase;           // 0 free, 1 waiting for downstream accept, 2 waiting for response
    int   n_checks = 0;
    int   n_pass   = 0;
    string grant_log;
`ifdef ARB_ROUND_ROBIN_EN
    logic tie_to_d;        // which port takes the next tie
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic txn_t mk_i(input logic [31:0] addr);
        txn_t t;
        t = '{v: 1'b1, wr: 1'b0, size: 2'd2, wstrb: 4'h0, addr: addr, wdata: 32'h0};
        return t;
    endfunction

    function automatic txn_t mk_d_rand();
        txn_t t;
        t.v     = 1'b1;
        t.wr    = 1'($urandom_range(0, 1));
        t.size  = 2'($urandom_range(0, 2));
        t.wstrb = 4'($urandom);
        t.addr  = $urandom;
        t.wdata = $urandom;
        return t;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic step(input logic rst, input logic maok, input logic mdok,
                        input logic [31:0] rdata);
        logic gi, gd, ido, ddo, in_req;
        reset     = rst;
        i_req     = pend_i.v;
        i_addr    = pend_i.addr;
        d_req     = pend_d.v;
        d_wr      = pend_d.wr;
        d_size    = pend_d.size;
        d_wstrb   = pend_d.wstrb;
        d_addr    = pend_d.addr;
        d_wdata   = pend_d.wdata;
        m_addr_ok = maok;
        m_data_ok = mdok;
        m_rdata   = rdata;

        gi = 1'b0;
        gd = 1'b0;
        if (!rst && phase == 0) begin
            if (pend_i.v && pend_d.v) begin
`ifdef ARB_ROUND_ROBIN_EN
                gd = tie_to_d;
`else
                gd = 1'b1;
`endif
                gi = !gd;
            end else begin
                gd = pend_d.v;
                gi = pend_i.v;
            end
        end
        in_req = !rst && phase == 1;
        ido = !rst && phase == 2 && mdok && !cur_d;
        ddo = !rst && phase == 2 && mdok && cur_d;

        #3;
        check("i_addr_ok", i_addr_ok, gi);
        check("d_addr_ok", d_addr_ok, gd);
        check("m_req", m_req, in_req);
        if (in_req) begin
            check("m_addr", m_addr, cur.addr);
            check("m_wr", m_wr, cur.wr);
            check("m_size", m_size, cur.size);
            check("m_wstrb", m_wstrb, cur.wstrb);
            check("m_wdata", m_wdata, cur.wdata);
        end
        check("i_data_ok", i_data_ok, ido);
        check("i_rdata", i_rdata, ido ? rdata : 32'h0);
        check("d_data_ok", d_data_ok, ddo);
        check("d_rdata", d_rdata, ddo ? rdata : 32'h0);

        @(posedge clk);
        #1;
        if (rst) begin
            phase = 0;
`ifdef ARB_ROUND_ROBIN_EN
            tie_to_d = 1'b1;
`endif
        end else if (gi || gd) begin
            if (gd) begin
                cur = pend_d;
                pend_d.v = 1'b0;
            end else begin
                cur = pend_i;
                pend_i.v = 1'b0;
            end
            cur_d = gd;
            grant_log = {grant_log, gd ? "D" : "I"};
`ifdef ARB_ROUND_ROBIN_EN
            tie_to_d = !gd;
`endif
            phase = 1;
        end else if (phase == 1 && maok) begin
            phase = 2;
        end else if (phase == 2 && mdok) begin
            phase = 0;
        end
    endtask

    initial begin
        txn_t t;
        reset = 1'b1;
        {i_req, d_req, d_wr, m_addr_ok, m_data_ok} = '0;
        {i_addr, d_addr, d_wdata, m_rdata, d_size, d_wstrb} = '0;
        pend_i = '0;
        pend_d = '0;
        cur    = '0;
        cur_d  = 1'b1;
        phase  = 0;
        grant_log = "";
`ifdef ARB_ROUND_ROBIN_EN
        tie_to_d = 1'b1;
`endif
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Lone I read with accept one cycle after m_req rises, response two cycles later.
        pend_i = mk_i(32'h1C00_0000);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0280_0000);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        // Simultaneous I read and D write; D wins the tie from reset.
        pend_i = mk_i(32'h1C00_0040);
        pend_d = '{v: 1'b1, wr: 1'b1, size: 2'd2, wstrb: 4'hF, addr: 32'h100,
                   wdata: 32'hDEAD_BEEF};
        grant_log = "";
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 1'b1, $urandom);
        check("tie_order", grant_log.len() >= 2 ? grant_log.substr(0, 1) == "DI" : 0, 1);

        // Both held high across four transactions.
        grant_log = "";
        for (int k = 0; k < 16; k++) begin
            if (!pend_i.v) pend_i = mk_i($urandom);
            if (!pend_d.v) pend_d = mk_d_rand();
            step(1'b0, 1'b1, 1'b1, $urandom);
        end
`ifdef ARB_ROUND_ROBIN_EN
        check("rr_order", grant_log.substr(0, 3) == "DIDI", 1);
`else
        check("fixed_order", grant_log.substr(0, 3) == "DDDD", 1);
`endif
        // Drain so the next scenario starts idle with nothing pending.
        for (int k = 0; k < 20 && (phase != 0 || pend_i.v || pend_d.v); k++)
            step(1'b0, 1'b1, 1'b1, $urandom);
        check("drained", phase == 0 && !pend_i.v && !pend_d.v, 1);

        // Accept withheld five cycles while D presents a different request.
        pend_d = mk_d_rand();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            t = mk_d_rand();
            t.addr = cur.addr ^ 32'h0000_1000 ^ (k << 4);
            pend_d = t;
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        for (int k = 0; k < 20 && (phase != 0 || pend_i.v || pend_d.v); k++)
            step(1'b0, 1'b1, 1'b1, $urandom);

        // Spurious downstream pulses while idle.
        step(1'b0, 1'b0, 1'b1, 32'h1234_5678);
        step(1'b0, 1'b1, 1'b1, 32'h8765_4321);
        check("idle_after_spurious", phase, 0);

        // Reset while waiting for the response, then a normal grant.
        pend_i = mk_i(32'h1C00_0080);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        pend_i = mk_i(32'h1C00_00C0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);

        // Random traffic with stray downstream pulses and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if (!pend_i.v && $urandom_range(0, 99) < 30) pend_i = mk_i($urandom);
            if (!pend_d.v && $urandom_range(0, 99) < 30) pend_d = mk_d_rand();
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
